// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the cycle gap between single-cycle pulses.
// Optional lock detection is built when PULSE_PERIOD_METER_LOCK_EN is defined.
module pulse_period_meter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         locked
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nx;
  logic [N-1:0] period_nx;
  logic         valid_nx;
  logic         meas;

  // Next state, counter and period; a pulse in MEASURE closes a measurement.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    period_nx = period;
    valid_nx  = 1'b0;
    meas      = 1'b0;
    if (!ena) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pulse_in) begin
            state_nx = MEASURE;
            cnt_nx   = '0;
          end
        end
        MEASURE: begin
          if (pulse_in) begin
            period_nx = cnt;
            valid_nx  = 1'b1;
            meas      = 1'b1;
            cnt_nx    = '0;
          end else if (&cnt) begin
            state_nx = TIMEOUT;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        TIMEOUT: begin
          if (pulse_in) begin
            state_nx = MEASURE;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      period  <= period_nx;
      valid   <= valid_nx;
      timeout <= (state_nx == TIMEOUT);
    end
  end

`ifdef PULSE_PERIOD_METER_LOCK_EN
  logic [N-1:0] prev;
  logic         prev_ok;

  // Lock when two consecutive measurements agree; any break drops history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      prev_ok <= 1'b0;
      locked  <= 1'b0;
    end else if (!ena || state_nx == TIMEOUT) begin
      prev_ok <= 1'b0;
      locked  <= 1'b0;
    end else if (meas) begin
      locked  <= prev_ok && (cnt == prev);
      prev    <= cnt;
      prev_ok <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: directed pulse trains checked against a
// time-stamp model of the meter plus literal expectations.
module tb_pulse_period_meter;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         pulse_in;
  logic [N-1:0] period;
  logic         valid;
  logic         timeout;
  logic         locked;

  int vectors = 0;
  int miscompares = 0;

  pulse_period_meter #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .pulse_in(pulse_in),
    .period  (period),
    .valid   (valid),
    .timeout (timeout),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: remembers the cycle of the last accepted pulse.
  int       cyc = 0;
  int       t_last = 0;
  bit       armed = 0;
  int       gap;
  logic [N-1:0] m_period = '0;
  logic     m_valid = 0;
  logic     m_to = 0;
  logic     m_lock = 0;
  logic [N-1:0] m_prev = '0;
  bit       m_prev_ok = 0;

  always @(posedge clk) begin
    if (rst) begin
      armed = 0; m_period = '0; m_valid = 0; m_to = 0;
      m_lock = 0; m_prev_ok = 0;
    end else begin
      cyc++;
      m_valid = 0;
      if (!ena) begin
        armed = 0; m_to = 0; m_lock = 0; m_prev_ok = 0;
      end else if (pulse_in) begin
        if (armed) begin
          gap = cyc - t_last - 1;
          m_period = gap[N-1:0];
          m_valid = 1;
`ifdef PULSE_PERIOD_METER_LOCK_EN
          m_lock = m_prev_ok && (m_prev == gap[N-1:0]);
          m_prev = gap[N-1:0];
          m_prev_ok = 1;
`endif
        end
        armed = 1; m_to = 0; t_last = cyc;
      end else if (armed && (cyc - t_last) >= (2 ** N)) begin
        armed = 0; m_to = 1; m_lock = 0; m_prev_ok = 0;
      end
    end
    #1;
    chk("model_period", period, m_period);
    chk("model_valid", valid, m_valid);
    chk("model_timeout", timeout, m_to);
    chk("model_locked", locked, m_lock);
  end

  task automatic step(input logic p);
    pulse_in = p;
    @(negedge clk);
  endtask

  task automatic pulse_after(input int z);
    repeat (z) step(1'b0);
    step(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    pulse_in = 1'b0;
    #12;
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;

    step(1'b1);
    chk("first_no_valid", valid, 0);
    pulse_after(4);
    chk("p5_valid", valid, 1);
    chk("p5_period", period, 4);
    pulse_after(4);
    chk("p5_valid3", valid, 1);
`ifdef PULSE_PERIOD_METER_LOCK_EN
    chk("p5_locked", locked, 1);
`endif
    step(1'b0);
    chk("valid_one_cycle", valid, 0);
    pulse_after(5);
    chk("gap7_period", period, 6);
    chk("gap7_valid", valid, 1);
    chk("gap7_locked", locked, 0);

    step(1'b1);
    chk("b2b_period", period, 0);
    chk("b2b_valid", valid, 1);

    pulse_after(255);
    chk("max_period", period, 255);
    chk("max_valid", valid, 1);
    chk("max_timeout", timeout, 0);

    repeat (255) step(1'b0);
    chk("pre_timeout", timeout, 0);
    step(1'b0);
    chk("timeout_set", timeout, 1);
    chk("timeout_period_held", period, 255);
    step(1'b1);
    chk("to_pulse_clear", timeout, 0);
    chk("to_pulse_no_valid", valid, 0);
    pulse_after(4);
    chk("after_to_valid", valid, 1);
    chk("after_to_period", period, 4);

    pulse_after(4);
    pulse_after(4);
`ifdef PULSE_PERIOD_METER_LOCK_EN
    chk("relock", locked, 1);
`endif
    ena = 1'b0;
    step(1'b0);
    step(1'b0);
    step(1'b1);
    chk("ena_off_no_valid", valid, 0);
    chk("ena_off_locked", locked, 0);
    chk("ena_off_period", period, 4);
    ena = 1'b1;
    step(1'b1);
    chk("ena_on_first", valid, 0);
    pulse_after(4);
    chk("ena_on_valid", valid, 1);
    chk("ena_on_period", period, 4);

    pulse_after(3);
    step(1'b0);
    step(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_period", period, 0);
    chk("arst_valid", valid, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    chk("post_rst_first", valid, 0);
    pulse_after(4);
    chk("post_rst_valid", valid, 1);
    chk("post_rst_period", period, 4);
    step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
